mod_exp_engine: RTL
===================

# mod_exp_engine

Parametrised modular-exponentiation engine computing result = base^exponent mod modulus by LSB-first square-and-multiply. It is the next-generation exponentiation core of the public-key encrypt/decrypt datapath. Relative to the first-generation core it adds width parameters, a start/busy/done handshake, asynchronous reset, abort, and a zero-modulus error flag. One engine serves both encryption and decryption; the caller supplies the public or private key as `exponent`.

## Interface

**Parameters**

- `WIDTH`, default 12: width of base, modulus and result. Internal products are 2*WIDTH bits.
- `EXPW`, default 12: width of the exponent.

**Ports**

- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request. Sampled only in IDLE.
- `abort`, input, 1: cancels a running operation. Ignored in IDLE.
- `base`, input, WIDTH: message or ciphertext. Captured on accepted start.
- `exponent`, input, EXPW: key. Captured on accepted start.
- `modulus`, input, WIDTH: n. Captured on accepted start.
- `busy`, output, 1: high from the cycle after an accepted start until the cycle done is asserted.
- `done`, output, 1: one-cycle completion pulse.
- `result`, output, WIDTH: registered result. Valid when done is high; held until the next done.
- `err`, output, 1: set with done when modulus == 0. Cleared on the next accepted start.

## Operation

**Internal registers**

- x (WIDTH)
- acc (WIDTH)
- y (EXPW)
- n (WIDTH)
- base latch (WIDTH)

All arithmetic uses 2*WIDTH-bit products reduced by `% n`. No truncation occurs before reduction.

**States**

- **IDLE**: if start, latch base, exponent and modulus, set busy=1, clear err, go to LOAD. Otherwise remain in IDLE.
- **LOAD**:
  - If n == 0: result=0, err=1, done=1, busy=0, go to IDLE.
  - Else: x = base % n, acc = 1 % n, y = exponent, go to MUL.
- **MUL**:
  - If y == 0: result = acc, done=1, busy=0, go to IDLE.
  - Else: if y[0] is set, acc = (acc*x) % n. Then y = y >> 1 and go to SQR.
- **SQR**: x = (x*x) % n, go to MUL.

**Abort and start rules**

- abort high in LOAD, MUL or SQR forces IDLE with busy=0. done is not pulsed, and result and err keep their previous values.
- start while busy is ignored. It does not queue.
- start and abort high together in IDLE: start is accepted and abort is ignored.

**Reset**

- Asserting rst_n low at any time, including mid-operation, immediately forces IDLE.
- Reset values: busy=0, done=0, result=0, err=0, and all internal registers 0.

## Timing

- Cycle 0 is the rising edge at which start is sampled high in IDLE.
- L is the bit length of the exponent: the index of its highest set bit plus 1, with L=0 for exponent 0.
- done is high for exactly the cycle following edge 2L+2. Latency is 2L+2 clocks.
- Maximum latency is 2*EXPW+2.
- Zero modulus: done and err assert after edge 1.
- busy is high after edges 0 through 2L+1 inclusive, and low together with the done edge.
- A new start may be sampled on the cycle done is high, since the state is then IDLE. Back-to-back operations are therefore spaced 2L+3 edges apart.
- Operands may change freely after the start edge.

## Test plan

- **Encrypt:** WIDTH=12, EXPW=12, base=65, exponent=17, modulus=3233 -> result=2790, err=0, done after edge 12, busy high for 12 cycles.
- **Decrypt:** base=2790, exponent=2753, modulus=3233 -> result=65, done after edge 26. Then issue back-to-back start on the done cycle with base=65, exponent=17 -> result=2790.
- **Edge operands:**
  - exponent=0, modulus=3233 -> result=1, done after edge 2.
  - modulus=1, base=7, exponent=5 -> result=0.
  - base=4000, exponent=1, modulus=3233 -> result=767.
- **Zero modulus:** modulus=0 -> done and err after edge 1, result=0. The next valid start clears err.
- **Abort:** assert abort at edge 6 of the 2753 job -> busy drops, no done, result still holds the prior value. Also pulse start at edges 3 and 5 while busy -> the pulses are ignored.
- **Reset:** rst_n low asynchronously mid-job (between edges) -> busy, done, result and err all go to 0 immediately. After release, a fresh 65^17 job completes normally.

Source files
------------

// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine: result = base^exponent mod modulus,
// LSB-first square-and-multiply with start/busy/done handshake and abort.
module mod_exp_engine #(
  parameter int WIDTH = 12,
  parameter int EXPW  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] base,
  input  logic [EXPW-1:0]  exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, LOAD, MUL, SQR} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x, x_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] n, n_nxt;
  logic [WIDTH-1:0] base_lat, base_lat_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic [EXPW-1:0]  y, y_nxt;
  logic             busy_nxt, done_nxt, err_nxt;

  // Reduce a double-width value modulo m; a zero modulus yields zero.
  function automatic logic [WIDTH-1:0] mod_red(input logic [2*WIDTH-1:0] v,
                                               input logic [WIDTH-1:0]   m);
    logic [2*WIDTH-1:0] r;
    if (m == '0) r = '0;
    else         r = v % {{WIDTH{1'b0}}, m};
    return r[WIDTH-1:0];
  endfunction

  // Full 2*WIDTH-bit product, reduced only after the multiply.
  function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return mod_red(p, m);
  endfunction

  always_comb begin
    state_nxt    = state;
    x_nxt        = x;
    acc_nxt      = acc;
    y_nxt        = y;
    n_nxt        = n;
    base_lat_nxt = base_lat;
    result_nxt   = result;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = err;

    if (state != IDLE && abort) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_lat_nxt = base;
            y_nxt        = exponent;
            n_nxt        = modulus;
            busy_nxt     = 1'b1;
            err_nxt      = 1'b0;
            state_nxt    = LOAD;
          end
        end
        LOAD: begin
          if (n == '0) begin
            result_nxt = '0;
            err_nxt    = 1'b1;
            done_nxt   = 1'b1;
            busy_nxt   = 1'b0;
            state_nxt  = IDLE;
          end else begin
            x_nxt     = mod_red({{WIDTH{1'b0}}, base_lat}, n);
            acc_nxt   = mod_red({{(2*WIDTH-1){1'b0}}, 1'b1}, n);
            state_nxt = MUL;
          end
        end
        MUL: begin
          if (y == '0) begin
            result_nxt = acc;
            done_nxt   = 1'b1;
            busy_nxt   = 1'b0;
            state_nxt  = IDLE;
          end else begin
            if (y[0]) acc_nxt = mod_mul(acc, x, n);
            y_nxt     = y >> 1;
            state_nxt = SQR;
          end
        end
        SQR: begin
          x_nxt     = mod_mul(x, x, n);
          state_nxt = MUL;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x        <= '0;
      acc      <= '0;
      y        <= '0;
      n        <= '0;
      base_lat <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      x        <= x_nxt;
      acc      <= acc_nxt;
      y        <= y_nxt;
      n        <= n_nxt;
      base_lat <= base_lat_nxt;
      result   <= result_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

endmodule
